rf_writeback_stage: RTL
=======================

// Module: rf_writeback_stage
// PURPOSE
//  Writeback stage directly upstream of the 32x64 register file (RF). Accepts retiring
//  instructions from the MEM stage and merges ALU results with load data returned by
//  data memory. Drives the RF write port (wrEn, rD, ppp, d_in) and a same-cycle bypass
//  copy for the decode stage. Throughput is one ALU op per cycle. Loads stall upstream
//  until memory answers or a timeout fires.
// PARAMETERS
//  LOAD_TIMEOUT  16  max cycles spent in WAIT_LOAD before the load is abandoned (>=2)
//  DW            64  datapath width; bit 0 is the MSB ([0:DW-1])
// PORTS
//  clk           in   1    single clock; all state updates on the rising edge
//  reset         in   1    asynchronous, active-low reset
//  in_valid      in   1    MEM stage presents a retiring instruction
//  in_ready      out  1    stage can accept; a transfer happens when in_valid & in_ready
//  in_wrEn       in   1    instruction writes a register
//  in_isLoad     in   1    result comes from dmem, not in_alu
//  in_rD         in   5    destination register
//  in_ppp        in   3    participation field: 000 all, 001 upper 32, 010 lower 32, 011 even bytes, 100 odd bytes
//  in_alu        in   DW   ALU result
//  dmem_valid    in   1    load data valid (single-cycle pulse)
//  dmem_dout     in   DW   load data
//  wrEn          out  1    RF write enable
//  rD            out  5    RF write address
//  ppp           out  3    RF participation field
//  d_in          out  DW   RF write data
//  fwd_valid     out  1    mirrors wrEn, for decode-stage bypass
//  err_ppp       out  1    1-cycle pulse: write dropped because ppp was 101..111
//  ld_timeout    out  1    1-cycle pulse: load abandoned
// BEHAVIOUR
//  Reset state (async assert):
//   - FSM enters IDLE.
//   - wrEn, fwd_valid, err_ppp and ld_timeout are 0.
//   - rD, ppp and d_in are 0.
//   - Timeout counter is 0.
//   - in_ready is 1 while reset is asserted and after it is released.
//  FSM states: IDLE, WAIT_LOAD. in_ready = (state == IDLE). Write outputs are registered.
//  IDLE, on transfer:
//   - in_wrEn=0: instruction consumed, nothing written. Next cycle wrEn=0.
//   - in_wrEn=1, in_isLoad=0, ppp legal: next cycle wrEn=1 with rD/ppp latched and
//     d_in=in_alu. Latency is 1 and back-to-back transfers write on consecutive cycles.
//   - in_wrEn=1, in_isLoad=1: latch rD/ppp, clear the counter, go to WAIT_LOAD.
//     Next cycle wrEn=0.
//   - in_wrEn=1 with in_ppp in 101..111: no write. err_ppp pulses next cycle.
//     A load with illegal ppp does not enter WAIT_LOAD.
//  WAIT_LOAD:
//   - in_ready=0; upstream holds its data.
//   - Counter increments each cycle.
//   - On dmem_valid: latch dmem_dout, go to IDLE. Next cycle wrEn=1 with d_in=load data.
//   - If counter == LOAD_TIMEOUT-1 with no dmem_valid: go to IDLE, pulse ld_timeout next
//     cycle, no write.
//   - If dmem_valid and expiry fall in the same cycle, the data wins: write, no timeout.
//  Other cycles:
//   - dmem_valid while in IDLE (stale or late response) is ignored.
//   - wrEn and fwd_valid are 0 on every cycle where no write was scheduled.
//   - rD/ppp/d_in hold their last value when wrEn=0.
//  Reset mid-operation: a pending load or write is discarded. A dmem_valid after reset
//  release is ignored as IDLE traffic.
//  ppp and data pass through unmodified. Subword masking is done by the RF.
// TESTING
//  1 Reset: pull reset low mid-WAIT_LOAD -> all outputs 0, in_ready=1; dmem_valid one
//    cycle after release produces no write.
//  2 ALU stream: 3 back-to-back transfers (rD=3,1,2; ppp=000,011,100; alu=1777777777)
//    -> wrEn=1 on 3 consecutive cycles, each exactly 1 cycle after its transfer.
//  3 Load: rD=4, ppp=000, isLoad=1; dmem_valid 3 cycles later with data=1555555587
//    -> in_ready=0 for 3 cycles, then wrEn=1 with rD=4, d_in=1555555587.
//  4 Timeout: load with no dmem_valid -> ld_timeout pulses once after LOAD_TIMEOUT
//    cycles, wrEn stays 0, in_ready returns to 1. A variant with dmem_valid on the
//    expiry cycle must write and not pulse ld_timeout.
//  5 Illegal ppp=110 with in_wrEn=1 -> err_ppp pulse, wrEn=0. in_wrEn=0 -> no write, no error.

Source files
------------

// File: rtl/rf_writeback_stage_if.sv
// Writeback-stage bundle: retiring-instruction handshake, dmem load return,
// and the RF write port with its decode-stage bypass copy.
interface rf_writeback_stage_if #(
    parameter int DW = 64
);
    logic          in_valid;
    logic          in_ready;
    logic          in_wrEn;
    logic          in_isLoad;
    logic [4:0]    in_rD;
    logic [2:0]    in_ppp;
    logic [0:DW-1] in_alu;
    logic          dmem_valid;
    logic [0:DW-1] dmem_dout;
    logic          wrEn;
    logic [4:0]    rD;
    logic [2:0]    ppp;
    logic [0:DW-1] d_in;
    logic          fwd_valid;
    logic          err_ppp;
    logic          ld_timeout;

    modport master (
        output in_valid, in_wrEn, in_isLoad, in_rD, in_ppp, in_alu,
        output dmem_valid, dmem_dout,
        input  in_ready, wrEn, rD, ppp, d_in, fwd_valid, err_ppp, ld_timeout
    );

    modport slave (
        input  in_valid, in_wrEn, in_isLoad, in_rD, in_ppp, in_alu,
        input  dmem_valid, dmem_dout,
        output in_ready, wrEn, rD, ppp, d_in, fwd_valid, err_ppp, ld_timeout
    );
endinterface

// File: rtl/rf_writeback_stage.sv
// Writeback stage feeding the 32x64 RF write port: ALU results pass with one cycle
// of latency, loads park in WAIT_LOAD until dmem answers or the timeout expires.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting instructions; ALU writes issue the next cycle
// WAIT_LOAD | load outstanding; upstream stalled, counter running
module rf_writeback_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int DW           = 64
) (
    input logic               clk,
    input logic               reset,
    rf_writeback_stage_if.slave bus
);
    localparam int CW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    rd_q, rd_d;
    logic [2:0]    ppp_q, ppp_d;
    logic [0:DW-1] d_in_q, d_in_d;
    logic [4:0]    pend_rd_q, pend_rd_d;
    logic [2:0]    pend_ppp_q, pend_ppp_d;
    logic          err_ppp_q, err_ppp_d;
    logic          ld_timeout_q, ld_timeout_d;

    logic          xfer;
    logic          ppp_legal;

    assign xfer      = bus.in_valid && (state_q == IDLE);
    assign ppp_legal = (bus.in_ppp <= 3'd4);

    // Load destination is held aside so rD/ppp on the RF port only change with a write.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        rd_d         = rd_q;
        ppp_d        = ppp_q;
        d_in_d       = d_in_q;
        pend_rd_d    = pend_rd_q;
        pend_ppp_d   = pend_ppp_q;
        err_ppp_d    = 1'b0;
        ld_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer && bus.in_wrEn) begin
                    if (!ppp_legal) begin
                        err_ppp_d = 1'b1;
                    end else if (bus.in_isLoad) begin
                        pend_rd_d  = bus.in_rD;
                        pend_ppp_d = bus.in_ppp;
                        cnt_d      = '0;
                        state_d    = WAIT_LOAD;
                    end else begin
                        wr_en_d = 1'b1;
                        rd_d    = bus.in_rD;
                        ppp_d   = bus.in_ppp;
                        d_in_d  = bus.in_alu;
                    end
                end
            end
            WAIT_LOAD: begin
                if (bus.dmem_valid) begin
                    wr_en_d = 1'b1;
                    rd_d    = pend_rd_q;
                    ppp_d   = pend_ppp_q;
                    d_in_d  = bus.dmem_dout;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ld_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            rd_q         <= '0;
            ppp_q        <= '0;
            d_in_q       <= '0;
            pend_rd_q    <= '0;
            pend_ppp_q   <= '0;
            err_ppp_q    <= 1'b0;
            ld_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            rd_q         <= rd_d;
            ppp_q        <= ppp_d;
            d_in_q       <= d_in_d;
            pend_rd_q    <= pend_rd_d;
            pend_ppp_q   <= pend_ppp_d;
            err_ppp_q    <= err_ppp_d;
            ld_timeout_q <= ld_timeout_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.wrEn       = wr_en_q;
    assign bus.fwd_valid  = wr_en_q;
    assign bus.rD         = rd_q;
    assign bus.ppp        = ppp_q;
    assign bus.d_in       = d_in_q;
    assign bus.err_ppp    = err_ppp_q;
    assign bus.ld_timeout = ld_timeout_q;
endmodule
